// File: rtl/enc_event_queue.sv
// enc_event_queue
//   Captures encoded request events from the upstream priority encoder into a
//   small FIFO and presents them to the dispatcher over a valid/ready handshake.
//   With DEDUP=1 only a new event (valid rising, or code change while valid)
//   is queued; with DEDUP=0 every valid cycle is queued. Events that arrive
//   while the queue is full (and nothing pops) are dropped, flagged by a
//   sticky overflow bit and counted by a saturating drop counter.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   y_in        : encoded code, meaningful when valid_in is high
//   valid_in    : encoder valid
//   out_ready   : consumer takes out_code this cycle
//   clr_ovf     : clears overflow and drop_cnt (wins over a same-cycle drop)
//   out_code    : registered head-of-queue code
//   out_valid   : queue non-empty
//   level       : occupancy 0..DEPTH
//   full/empty  : level == DEPTH / level == 0
//   overflow    : sticky, an event was dropped
//   drop_cnt    : saturating count of dropped events
module enc_event_queue #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 2,
    parameter int DEDUP  = 1,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CODE_W-1:0]        y_in,
    input  logic                     valid_in,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic [CODE_W-1:0]        out_code,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic              last_valid;
    logic [CODE_W-1:0] last_code;
    logic              ev, pop, push, drop;
    logic [LW-1:0]     level_nxt;
    logic [CODE_W-1:0] head_nxt;

    always_comb begin
        ev   = valid_in && ((DEDUP == 0) || !last_valid || (y_in != last_code));
        pop  = out_valid && out_ready;
        push = ev && (!full || pop);
        drop = ev && full && !pop;

        level_nxt = level;
        if (push && !pop)
            level_nxt = level + LW'(1);
        else if (pop && !push)
            level_nxt = level - LW'(1);

        rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        // The entry being written this cycle becomes the head only when the
        // queue is empty after the pop; otherwise the head is already stored.
        head_nxt = (push && (wr_ptr == rd_nxt)) ? y_in : mem[rd_nxt];
    end

    // Storage carries no reset; occupancy tracking makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= y_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            out_valid  <= 1'b0;
            out_code   <= '0;
            last_valid <= 1'b0;
            last_code  <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            last_valid <= valid_in;
            if (valid_in)
                last_code <= y_in;

            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_nxt;
            level     <= level_nxt;
            full      <= (level_nxt == LW'(DEPTH));
            empty     <= (level_nxt == '0);
            out_valid <= (level_nxt != '0);

            // Head register only moves when the queue changes and stays
            // non-empty, so it holds while idle or stalled.
            if ((push || pop) && (level_nxt != '0))
                out_code <= head_nxt;

            if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end
endmodule
